// File: rtl/issue_ctrl.sv
// -----------------------------------------------------------------------------
// issue_ctrl
//   Decode-to-execute issue controller for an in-order scalar pipeline.
//   Tracks the destination registers of instructions in EX, MEM and WB,
//   produces operand forwarding selects for the instruction sitting in decode,
//   inserts bubbles on load-use hazards and MEM back-pressure, and counts the
//   cycles in which a valid decoded instruction could not issue.
//
// Ports
//   clock, reset          core clock, synchronous active-high reset
//   id_valid / id_ready   decoder handshake; id_ready = issued into EX now
//   A_reg, A_reg_valid    source A index / instruction reads A
//   B_reg, B_reg_valid    source B index / instruction reads B
//   B_need_late           B is consumed in MEM (store data), not in EX
//   dest_reg(_valid)      destination index / instruction writes it
//   load_inst             instruction is a load
//   mem_stall             MEM cannot advance; the whole pipe holds
//   ex_valid              EX holds a real instruction (0 = bubble)
//   fwd_a_sel, fwd_b_sel  0 regfile, 1 EX, 2 MEM, 3 WB result
//   fwd_b_late            B is taken from the WB result while in MEM
//   stall_cycles          cycles with id_valid=1 and id_ready=0
// -----------------------------------------------------------------------------
module issue_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [4:0]           A_reg,
  input  logic                 A_reg_valid,
  input  logic [4:0]           B_reg,
  input  logic                 B_reg_valid,
  input  logic                 B_need_late,
  input  logic [4:0]           dest_reg,
  input  logic                 dest_reg_valid,
  input  logic                 load_inst,
  input  logic                 mem_stall,
  output logic                 ex_valid,
  output logic [1:0]           fwd_a_sel,
  output logic [1:0]           fwd_b_sel,
  output logic                 fwd_b_late,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_EX  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_WB  = 2'd3;

  // In-flight slots. A slot is only marked valid when it really produces a
  // register write to a non-zero register, so r0 never creates a hazard.
  logic       ex_slot_valid, mem_slot_valid, wb_slot_valid;
  logic [4:0] ex_slot_dest,  mem_slot_dest,  wb_slot_dest;
  logic       ex_slot_load,  mem_slot_load,  wb_slot_load;
  logic       ex_valid_reg;
  logic [CNT_WIDTH-1:0] stall_cnt_reg;

  // Source qualification: reading r0 never needs forwarding.
  logic a_chk, b_chk;
  logic a_ex, a_mem, a_wb;
  logic b_ex, b_mem, b_wb;
  logic load_use_stall;
  logic b_late_hit;

  assign a_chk = A_reg_valid && (A_reg != 5'd0);
  assign b_chk = B_reg_valid && (B_reg != 5'd0);

  assign a_ex  = a_chk && ex_slot_valid  && (ex_slot_dest  == A_reg);
  assign a_mem = a_chk && mem_slot_valid && (mem_slot_dest == A_reg);
  assign a_wb  = a_chk && wb_slot_valid  && (wb_slot_dest  == A_reg);
  assign b_ex  = b_chk && ex_slot_valid  && (ex_slot_dest  == B_reg);
  assign b_mem = b_chk && mem_slot_valid && (mem_slot_dest == B_reg);
  assign b_wb  = b_chk && wb_slot_valid  && (wb_slot_dest  == B_reg);

  // Store data from a load one ahead: the load result is in WB exactly when
  // the store reaches MEM, so no bubble is needed.
  assign b_late_hit = b_ex && ex_slot_load && B_need_late;

  assign load_use_stall = ex_slot_load && (a_ex || (b_ex && !B_need_late));

  assign id_ready   = id_valid && !mem_stall && !load_use_stall;
  assign fwd_b_late = b_late_hit;

  // Youngest producer wins: EX > MEM > WB > regfile.
  always_comb begin
    fwd_a_sel = SEL_RF;
    if (a_ex)       fwd_a_sel = SEL_EX;
    else if (a_mem) fwd_a_sel = SEL_MEM;
    else if (a_wb)  fwd_a_sel = SEL_WB;
  end

  always_comb begin
    fwd_b_sel = SEL_RF;
    if (b_late_hit)  fwd_b_sel = SEL_RF;
    else if (b_ex)   fwd_b_sel = SEL_EX;
    else if (b_mem)  fwd_b_sel = SEL_MEM;
    else if (b_wb)   fwd_b_sel = SEL_WB;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_slot_valid  <= 1'b0;
      ex_slot_dest   <= 5'd0;
      ex_slot_load   <= 1'b0;
      mem_slot_valid <= 1'b0;
      mem_slot_dest  <= 5'd0;
      mem_slot_load  <= 1'b0;
      wb_slot_valid  <= 1'b0;
      wb_slot_dest   <= 5'd0;
      wb_slot_load   <= 1'b0;
      ex_valid_reg   <= 1'b0;
    end else if (!mem_stall) begin
      wb_slot_valid  <= mem_slot_valid;
      wb_slot_dest   <= mem_slot_dest;
      wb_slot_load   <= mem_slot_load;
      mem_slot_valid <= ex_slot_valid;
      mem_slot_dest  <= ex_slot_dest;
      mem_slot_load  <= ex_slot_load;
      // A bubble (id_ready=0) enters EX as an empty, non-load slot.
      ex_slot_valid  <= id_ready && dest_reg_valid && (dest_reg != 5'd0);
      ex_slot_dest   <= dest_reg;
      ex_slot_load   <= id_ready && load_inst;
      ex_valid_reg   <= id_ready;
    end
  end

  // mem_stall and load-use in the same cycle still count as one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (id_valid && !id_ready) begin
      stall_cnt_reg <= stall_cnt_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign ex_valid     = ex_valid_reg;
  assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_issue_ctrl
//   Directed self-checking bench for issue_ctrl. Inputs change 1 time unit
//   after the rising edge; outputs are sampled mid-cycle.
// -----------------------------------------------------------------------------
module tb_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  A_reg;
  logic        A_reg_valid;
  logic [4:0]  B_reg;
  logic        B_reg_valid;
  logic        B_need_late;
  logic [4:0]  dest_reg;
  logic        dest_reg_valid;
  logic        load_inst;
  logic        mem_stall;
  logic        ex_valid;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        fwd_b_late;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  issue_ctrl #(.CNT_WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .A_reg          (A_reg),
    .A_reg_valid    (A_reg_valid),
    .B_reg          (B_reg),
    .B_reg_valid    (B_reg_valid),
    .B_need_late    (B_need_late),
    .dest_reg       (dest_reg),
    .dest_reg_valid (dest_reg_valid),
    .load_inst      (load_inst),
    .mem_stall      (mem_stall),
    .ex_valid       (ex_valid),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .fwd_b_late     (fwd_b_late),
    .stall_cycles   (stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Present one decoded instruction and let combinational outputs settle.
  task automatic pres(input logic v, input logic [4:0] a, input logic av,
                      input logic [4:0] b, input logic bv, input logic late,
                      input logic [4:0] d, input logic dv, input logic ld);
    id_valid       = v;
    A_reg          = a;
    A_reg_valid    = av;
    B_reg          = b;
    B_reg_valid    = bv;
    B_need_late    = late;
    dest_reg       = d;
    dest_reg_valid = dv;
    load_inst      = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    pres(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset     = 1'b1;
    mem_stall = 1'b0;
    pres(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_fwd_a", fwd_a_sel, 0);
    chk("rst_fwd_b", fwd_b_sel, 0);
    chk("rst_late", fwd_b_late, 0);
    reset = 1'b0;

    // addu r3,r1,r2
    pres(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    chk("add_ready", id_ready, 1);
    chk("add_fwd_a", fwd_a_sel, 0);
    chk("add_fwd_b", fwd_b_sel, 0);
    tick();
    chk("add_ex_valid", ex_valid, 1);

    // addu r4,r3,r3 : r3 in EX
    pres(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
    chk("dep_ex_ready", id_ready, 1);
    chk("dep_ex_fwd_a", fwd_a_sel, 1);
    chk("dep_ex_fwd_b", fwd_b_sel, 1);
    tick();
    // EX=r4 MEM=r3 : A reads r3, B reads r4 (different slots)
    pres(1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("mix1_fwd_a", fwd_a_sel, 2);
    chk("mix1_fwd_b", fwd_b_sel, 1);
    tick();
    // EX=- MEM=r4 WB=r3
    chk("mix2_fwd_a", fwd_a_sel, 3);
    chk("mix2_fwd_b", fwd_b_sel, 2);
    tick();
    // WB=r4, r3 retired
    chk("mix3_fwd_a", fwd_a_sel, 0);
    chk("mix3_fwd_b", fwd_b_sel, 3);
    tick();
    chk("mix4_fwd_b", fwd_b_sel, 0);
    chk("idle_no_cnt", stall_cycles, 0);

    // Youngest wins: r9 in both EX and MEM
    pres(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    tick();
    pres(1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("young_fwd_a", fwd_a_sel, 1);
    idle(3);

    // lw r5,0(r1) then addu r6,r5,r0
    pres(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    chk("lw_ready", id_ready, 1);
    tick();
    pres(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    chk("lu_ready", id_ready, 0);
    tick();
    chk("lu_ex_valid", ex_valid, 0);
    chk("lu_stall_cnt", stall_cycles, 1);
    chk("lu2_ready", id_ready, 1);
    chk("lu2_fwd_a", fwd_a_sel, 2);
    tick();
    chk("lu2_ex_valid", ex_valid, 1);
    idle(3);

    // lw r5 then sw r5,0(r2): store data forwarded late
    pres(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    pres(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("sw_ready", id_ready, 1);
    chk("sw_late", fwd_b_late, 1);
    chk("sw_fwd_b", fwd_b_sel, 0);
    chk("sw_fwd_a", fwd_a_sel, 0);
    // Same store but address base r5 -> load-use on A
    pres(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("swa_ready", id_ready, 0);
    tick();
    chk("swa_stall_cnt", stall_cycles, 2);
    chk("swa2_ready", id_ready, 1);
    chk("swa2_fwd_a", fwd_a_sel, 2);
    chk("swa2_fwd_b", fwd_b_sel, 2);
    chk("swa2_late", fwd_b_late, 0);
    tick();
    idle(3);

    // Writes to r0 never create hazards
    pres(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    pres(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
    chk("r0_ready", id_ready, 1);
    chk("r0_fwd_a", fwd_a_sel, 0);
    pres(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    pres(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
    chk("lw0_ready", id_ready, 1);
    chk("lw0_fwd_a", fwd_a_sel, 0);
    chk("lw0_fwd_b", fwd_b_sel, 0);
    tick();
    idle(3);
    chk("r0_stall_cnt", stall_cycles, 2);

    // mem_stall for 3 cycles with a reader of r10 waiting
    pres(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    mem_stall = 1'b1;
    pres(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
    chk("ms_ready", id_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ms_ex_valid", ex_valid, 1);
      chk("ms_fwd_a", fwd_a_sel, 1);
    end
    chk("ms_stall_cnt", stall_cycles, 5);
    // Reset in the middle of the stall
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("msr_ex_valid", ex_valid, 0);
    chk("msr_stall_cnt", stall_cycles, 0);
    chk("msr_fwd_a", fwd_a_sel, 0);
    chk("msr_ready", id_ready, 0);
    mem_stall = 1'b0;
    #1;
    chk("msr2_ready", id_ready, 1);

    // Load-use and mem_stall together count once
    pres(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1);
    tick();
    mem_stall = 1'b1;
    pres(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 5'd13, 1'b1, 1'b0);
    tick();
    chk("both_stall_cnt", stall_cycles, 1);
    mem_stall = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
